alu_bist: RTL and testbench
===========================

// Module: alu_bist
// PURPOSE
// - Built-in self-test initiator for the AlicePU ALU: drives op/in1/in2/shift_imm from an internal golden-vector ROM and checks out/zero/neg.
// - Sits beside Alu behind a test mux; the core is held while it runs.
// - Reports pass/fail, the fail count and the first failing vector index.
// PARAMETERS
// - SETTLE_CYCLES  1  cycles between driving a vector and sampling the result; legal range 1..15.
// - STOP_ON_FAIL   0  1 = end the run at the first mismatch.
// PORTS
// - clk             in   1   clock; all state updates on the rising edge.
// - rst_n           in   1   asynchronous reset, active-low.
// - start           in   1   run request; honoured only in IDLE.
// - abort           in   1   synchronous abort; returns to IDLE from any state.
// - busy            out  1   high in every state except IDLE.
// - done            out  1   one-cycle pulse when a run completes.
// - pass            out  1   result of the last completed run, held until the next start.
// - fail_count      out  5   number of mismatching vectors in the current/last run.
// - first_fail_idx  out  5   index of the first mismatch; 5'h1F if none.
// - alu_op          out  `ALU_OP_LEN  to Alu.op.
// - alu_in1         out  32  to Alu.in1 (shift amount for *V shifts).
// - alu_in2         out  32  to Alu.in2.
// - alu_shift_imm   out  5   to Alu.shift_imm.
// - alu_out         in   32  from Alu.out.
// - alu_zero        in   1   from Alu.zero.
// - alu_neg         in   1   from Alu.neg.
// - cap_out         out  32  actual alu_out of the first failing vector (ALU_BIST_CAPTURE_EN only).
// - cap_flags       out  2   {zero,neg} of the first failing vector (ALU_BIST_CAPTURE_EN only).
// BEHAVIOUR
// - Reset state:
//   - State IDLE; busy=0, done=0, pass=0, fail_count=0, first_fail_idx=5'h1F.
//   - ALU drive outputs: alu_op=`ALU_OP_NONE, alu_in1=0, alu_in2=0, alu_shift_imm=0, cap_*=0.
// - Vector ROM: 17 entries, idx 0..16, fields {op,in1,in2,shamt,exp}. Expected flags are zero=(exp==0), neg=exp[31].
//   - 0  ADD   1,2 -> 3
//   - 1  ADD   7fffffff,1 -> 80000000
//   - 2  SUB   2,2 -> 0
//   - 3  MUL   2,3 -> 6
//   - 4  DIV   7,3 -> 2
//   - 5  MOD   7,3 -> 1
//   - 6  SLT   1,2 -> 1
//   - 7  AND   00ff00ff,0000ffff -> 000000ff
//   - 8  OR    (same operands) -> 00ffffff
//   - 9  XOR   (same operands) -> 00ffff00
//   - 10 NOR   (same operands) -> ff000000
//   - 11 SLL   b=000ff000, sh=4 -> 00ff0000
//   - 12 SLLV  a=8, b=000ff000 -> 0ff00000
//   - 13 SRL   b=000ff000, sh=4 -> 0000ff00
//   - 14 SRLV  a=8, b=000ff000 -> 00000ff0
//   - 15 SRA   b=fffffff8, sh=1 -> fffffffc
//   - 16 SRAV  a=2, b=fffffff8 -> fffffffe
//   - Unused fields are 0.
// - FSM:
//   - IDLE  -> DRIVE on start & !abort. Clears fail_count, pass, first_fail_idx (to 1F); idx=0.
//   - DRIVE: registers ROM[idx] onto the alu_* outputs (1 cycle) -> WAIT.
//   - WAIT:  counts SETTLE_CYCLES cycles -> CHECK.
//   - CHECK: compares {alu_out,alu_zero,alu_neg} with the expected values.
//     - On mismatch: fail_count++ and, if it is the first failure, first_fail_idx=idx.
//     - Next: idx==16, or (STOP_ON_FAIL && mismatch) -> DONE; otherwise idx++ -> DRIVE.
//   - DONE:  done=1 and pass=(fail_count==0) for one cycle; alu_* return to reset values -> IDLE.
// - Latency: (2+SETTLE_CYCLES) cycles per vector. With SETTLE_CYCLES=1, a clean run is 51 cycles from the start-accept edge to the done pulse.
// - Boundaries:
//   - start while busy is ignored.
//   - abort has priority over start and every transition. The next cycle is IDLE: alu_* at reset values, no done pulse, pass=0; fail_count and first_fail_idx are kept.
//   - rst_n low mid-run forces reset values immediately.
//   - fail_count saturates at 31 (max reachable is 17).
// CONFIGURATION
// - ALU_BIST_CAPTURE_EN defined:
//   - On the first mismatch, cap_out/cap_flags latch the actual alu_out/{alu_zero,alu_neg}.
//   - They are cleared on start and held after done.
// - ALU_BIST_CAPTURE_EN undefined:
//   - cap_out=0 and cap_flags=0 constantly; no capture registers are built.
// TESTING
// - Golden Alu attached, SETTLE=1, start pulse -> done at +51 cycles; pass=1, fail_count=0, first_fail_idx=1F.
// - Bench inverts alu_out[0] when op==ADD -> pass=0, fail_count=2, first_fail_idx=0; with CAPTURE_EN: cap_out=00000002, cap_flags=2'b00.
// - Same fault with STOP_ON_FAIL=1 -> done at +3 cycles; fail_count=1, first_fail_idx=0.
// - Forced zero=1 on SUB removed (zero=0) -> fail_count=1, first_fail_idx=2.
// - abort 10 cycles after start -> busy=0 next cycle, no done pulse, alu_op=`ALU_OP_NONE, pass=0.
// - rst_n low at cycle 20 of a run -> all outputs at reset values that cycle; a following start gives a full clean run (pass=1).

Source files
------------

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test initiator for the AlicePU ALU. Walks a 17-entry
// golden-vector ROM and drives each vector onto the ALU. It checks out/zero/neg,
// then reports pass/fail, the fail count and the first failing index.
// Ports: clk, rst_n (async, active-low), start/abort control, busy/done/pass and
// fail_count/first_fail_idx status, and the alu_op/alu_in1/alu_in2/alu_shift_imm
// drive outputs. alu_out/alu_zero/alu_neg are the sampled ALU results.
// cap_out/cap_flags hold the first failing result.
// Optional: define ALU_BIST_CAPTURE_EN to build the first-failure capture
// registers. Without it, cap_out/cap_flags are tied to zero.

`ifndef ALU_OP_LEN
`define ALU_OP_LEN 5
`endif
`ifndef ALU_OP_NONE
`define ALU_OP_NONE 5'd0
`define ALU_OP_ADD  5'd1
`define ALU_OP_SUB  5'd2
`define ALU_OP_MUL  5'd3
`define ALU_OP_DIV  5'd4
`define ALU_OP_MOD  5'd5
`define ALU_OP_SLT  5'd6
`define ALU_OP_AND  5'd7
`define ALU_OP_OR   5'd8
`define ALU_OP_XOR  5'd9
`define ALU_OP_NOR  5'd10
`define ALU_OP_SLL  5'd11
`define ALU_OP_SLLV 5'd12
`define ALU_OP_SRL  5'd13
`define ALU_OP_SRLV 5'd14
`define ALU_OP_SRA  5'd15
`define ALU_OP_SRAV 5'd16
`endif

module alu_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [4:0]             fail_count,
  output logic [4:0]             first_fail_idx,
  output logic [`ALU_OP_LEN-1:0] alu_op,
  output logic [31:0]            alu_in1,
  output logic [31:0]            alu_in2,
  output logic [4:0]             alu_shift_imm,
  input  logic [31:0]            alu_out,
  input  logic                   alu_zero,
  input  logic                   alu_neg,
  output logic [31:0]            cap_out,
  output logic [1:0]             cap_flags
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    logic [`ALU_OP_LEN-1:0] op;
    logic [31:0]            in1;
    logic [31:0]            in2;
    logic [4:0]             sh;
    logic [31:0]            exp;
  } vec_t;

  localparam logic [4:0] LAST_IDX = 5'd16;
  localparam logic [4:0] NO_FAIL  = 5'h1F;

  // Golden vectors; in1 carries the shift amount for the variable shifts.
  function automatic vec_t rom(input logic [4:0] i);
    vec_t v;
    v = '0;
    case (i)
      5'd0:  v = '{`ALU_OP_ADD,  32'h1,        32'h2,        5'd0, 32'h3};
      5'd1:  v = '{`ALU_OP_ADD,  32'h7fffffff, 32'h1,        5'd0, 32'h80000000};
      5'd2:  v = '{`ALU_OP_SUB,  32'h2,        32'h2,        5'd0, 32'h0};
      5'd3:  v = '{`ALU_OP_MUL,  32'h2,        32'h3,        5'd0, 32'h6};
      5'd4:  v = '{`ALU_OP_DIV,  32'h7,        32'h3,        5'd0, 32'h2};
      5'd5:  v = '{`ALU_OP_MOD,  32'h7,        32'h3,        5'd0, 32'h1};
      5'd6:  v = '{`ALU_OP_SLT,  32'h1,        32'h2,        5'd0, 32'h1};
      5'd7:  v = '{`ALU_OP_AND,  32'h00ff00ff, 32'h0000ffff, 5'd0, 32'h000000ff};
      5'd8:  v = '{`ALU_OP_OR,   32'h00ff00ff, 32'h0000ffff, 5'd0, 32'h00ffffff};
      5'd9:  v = '{`ALU_OP_XOR,  32'h00ff00ff, 32'h0000ffff, 5'd0, 32'h00ffff00};
      5'd10: v = '{`ALU_OP_NOR,  32'h00ff00ff, 32'h0000ffff, 5'd0, 32'hff000000};
      5'd11: v = '{`ALU_OP_SLL,  32'h0,        32'h000ff000, 5'd4, 32'h00ff0000};
      5'd12: v = '{`ALU_OP_SLLV, 32'h8,        32'h000ff000, 5'd0, 32'h0ff00000};
      5'd13: v = '{`ALU_OP_SRL,  32'h0,        32'h000ff000, 5'd4, 32'h0000ff00};
      5'd14: v = '{`ALU_OP_SRLV, 32'h8,        32'h000ff000, 5'd0, 32'h00000ff0};
      5'd15: v = '{`ALU_OP_SRA,  32'h0,        32'hfffffff8, 5'd1, 32'hfffffffc};
      5'd16: v = '{`ALU_OP_SRAV, 32'h2,        32'hfffffff8, 5'd0, 32'hfffffffe};
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t                 state_q, state_d;
  logic [4:0]             idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [4:0]             fail_count_q, fail_count_d;
  logic [4:0]             first_fail_idx_q, first_fail_idx_d;
  logic                   pass_q, pass_d;
  logic [`ALU_OP_LEN-1:0] alu_op_q, alu_op_d;
  logic [31:0]            alu_in1_q, alu_in1_d;
  logic [31:0]            alu_in2_q, alu_in2_d;
  logic [4:0]             alu_shift_imm_q, alu_shift_imm_d;

  vec_t cur;
  logic mismatch;
  logic run_clr;
  logic first_miss;

  // The drive registers hold ROM[idx_q] from WAIT through CHECK, so the ROM
  // entry used here matches what the ALU is currently computing.
  assign cur        = rom(idx_q);
  assign mismatch   = (alu_out != cur.exp) || (alu_zero != (cur.exp == 32'd0)) ||
                      (alu_neg != cur.exp[31]);
  assign run_clr    = (state_q == S_IDLE) && start && !abort;
  assign first_miss = (state_q == S_CHECK) && mismatch && (fail_count_q == 5'd0) && !abort;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    fail_count_d     = fail_count_q;
    first_fail_idx_d = first_fail_idx_q;
    pass_d           = pass_q;
    alu_op_d         = alu_op_q;
    alu_in1_d        = alu_in1_q;
    alu_in2_d        = alu_in2_q;
    alu_shift_imm_d  = alu_shift_imm_q;
    case (state_q)
      S_IDLE: begin
        if (run_clr) begin
          fail_count_d     = 5'd0;
          first_fail_idx_d = NO_FAIL;
          pass_d           = 1'b0;
          idx_d            = 5'd0;
          state_d          = S_DRIVE;
        end
      end
      S_DRIVE: begin
        alu_op_d        = cur.op;
        alu_in1_d       = cur.in1;
        alu_in2_d       = cur.in2;
        alu_shift_imm_d = cur.sh;
        cnt_d           = 4'd0;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = S_CHECK;
        else                                cnt_d   = cnt_q + 4'd1;
      end
      S_CHECK: begin
        if (mismatch && (fail_count_q != 5'd31)) fail_count_d = fail_count_q + 5'd1;
        if (first_miss) first_fail_idx_d = idx_q;
        if ((idx_q == LAST_IDX) || (STOP_ON_FAIL && mismatch)) begin
          // Registered on entry to DONE so pass is valid alongside done.
          pass_d  = (fail_count_d == 5'd0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        alu_op_d        = `ALU_OP_NONE;
        alu_in1_d       = 32'd0;
        alu_in2_d       = 32'd0;
        alu_shift_imm_d = 5'd0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything; the run's counters are left for inspection.
    if (abort) begin
      state_d         = S_IDLE;
      pass_d          = 1'b0;
      alu_op_d        = `ALU_OP_NONE;
      alu_in1_d       = 32'd0;
      alu_in2_d       = 32'd0;
      alu_shift_imm_d = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      idx_q            <= 5'd0;
      cnt_q            <= 4'd0;
      fail_count_q     <= 5'd0;
      first_fail_idx_q <= NO_FAIL;
      pass_q           <= 1'b0;
      alu_op_q         <= `ALU_OP_NONE;
      alu_in1_q        <= 32'd0;
      alu_in2_q        <= 32'd0;
      alu_shift_imm_q  <= 5'd0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      fail_count_q     <= fail_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      pass_q           <= pass_d;
      alu_op_q         <= alu_op_d;
      alu_in1_q        <= alu_in1_d;
      alu_in2_q        <= alu_in2_d;
      alu_shift_imm_q  <= alu_shift_imm_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_idx_q;
  assign alu_op         = alu_op_q;
  assign alu_in1        = alu_in1_q;
  assign alu_in2        = alu_in2_q;
  assign alu_shift_imm  = alu_shift_imm_q;

`ifdef ALU_BIST_CAPTURE_EN
  logic [31:0] cap_out_q, cap_out_d;
  logic [1:0]  cap_flags_q, cap_flags_d;

  always_comb begin
    cap_out_d   = cap_out_q;
    cap_flags_d = cap_flags_q;
    if (run_clr) begin
      cap_out_d   = 32'd0;
      cap_flags_d = 2'b00;
    end else if (first_miss) begin
      cap_out_d   = alu_out;
      cap_flags_d = {alu_zero, alu_neg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_out_q   <= 32'd0;
      cap_flags_q <= 2'b00;
    end else begin
      cap_out_q   <= cap_out_d;
      cap_flags_q <= cap_flags_d;
    end
  end

  assign cap_out   = cap_out_q;
  assign cap_flags = cap_flags_q;
`else
  assign cap_out   = 32'd0;
  assign cap_flags = 2'b00;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: self-checking bench for alu_bist. Two instances run side by side,
// one continuing after mismatches and one stopping at the first. A behavioural
// ALU with per-opcode fault injection sits behind each instance.

`ifndef ALU_OP_LEN
`define ALU_OP_LEN 5
`endif
`ifndef ALU_OP_NONE
`define ALU_OP_NONE 5'd0
`define ALU_OP_ADD  5'd1
`define ALU_OP_SUB  5'd2
`define ALU_OP_MUL  5'd3
`define ALU_OP_DIV  5'd4
`define ALU_OP_MOD  5'd5
`define ALU_OP_SLT  5'd6
`define ALU_OP_AND  5'd7
`define ALU_OP_OR   5'd8
`define ALU_OP_XOR  5'd9
`define ALU_OP_NOR  5'd10
`define ALU_OP_SLL  5'd11
`define ALU_OP_SLLV 5'd12
`define ALU_OP_SRL  5'd13
`define ALU_OP_SRLV 5'd14
`define ALU_OP_SRA  5'd15
`define ALU_OP_SRAV 5'd16
`endif

module tb_alu_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  // Instance a: run to completion. Instance b: stop on first failure.
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [4:0] fc_a, ffi_a, sh_a, fc_b, ffi_b, sh_b;
  logic [`ALU_OP_LEN-1:0] op_a, op_b;
  logic [31:0] in1_a, in2_a, out_a, cap_a, in1_b, in2_b, out_b, cap_b;
  logic zero_a, neg_a, zero_b, neg_b;
  logic [1:0] capf_a, capf_b;

  alu_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a), .first_fail_idx(ffi_a),
    .alu_op(op_a), .alu_in1(in1_a), .alu_in2(in2_a), .alu_shift_imm(sh_a),
    .alu_out(out_a), .alu_zero(zero_a), .alu_neg(neg_a), .cap_out(cap_a), .cap_flags(capf_a));

  alu_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u_dut_sof (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b), .first_fail_idx(ffi_b),
    .alu_op(op_b), .alu_in1(in1_b), .alu_in2(in2_b), .alu_shift_imm(sh_b),
    .alu_out(out_b), .alu_zero(zero_b), .alu_neg(neg_b), .cap_out(cap_b), .cap_flags(capf_b));

  // Fault injection per opcode: XOR onto the result, then XOR onto {zero,neg}.
  logic [31:0] f_xor  [0:31];
  logic [1:0]  f_flag [0:31];

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      `ALU_OP_ADD:  return a + b;
      `ALU_OP_SUB:  return a - b;
      `ALU_OP_MUL:  return a * b;
      `ALU_OP_DIV:  return (b == 0) ? 32'd0 : a / b;
      `ALU_OP_MOD:  return (b == 0) ? 32'd0 : a % b;
      `ALU_OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      `ALU_OP_AND:  return a & b;
      `ALU_OP_OR:   return a | b;
      `ALU_OP_XOR:  return a ^ b;
      `ALU_OP_NOR:  return ~(a | b);
      `ALU_OP_SLL:  return b << sh;
      `ALU_OP_SLLV: return b << a[4:0];
      `ALU_OP_SRL:  return b >> sh;
      `ALU_OP_SRLV: return b >> a[4:0];
      `ALU_OP_SRA:  return $signed(b) >>> sh;
      `ALU_OP_SRAV: return $signed(b) >>> a[4:0];
      default:      return 32'd0;
    endcase
  endfunction

  always_comb begin
    out_a  = alu_fn(op_a, in1_a, in2_a, sh_a) ^ f_xor[op_a];
    zero_a = (out_a == 32'd0) ^ f_flag[op_a][1];
    neg_a  = out_a[31] ^ f_flag[op_a][0];
    out_b  = alu_fn(op_b, in1_b, in2_b, sh_b) ^ f_xor[op_b];
    zero_b = (out_b == 32'd0) ^ f_flag[op_b][1];
    neg_b  = out_b[31] ^ f_flag[op_b][0];
  end

  // Golden vector list as written in the block description.
  logic [4:0]  tv_op [0:16];
  logic [31:0] tv_a [0:16], tv_b [0:16], tv_e [0:16];
  logic [4:0]  tv_sh [0:16];

  task automatic set_tv(input int i, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] e);
    tv_op[i] = op; tv_a[i] = a; tv_b[i] = b; tv_sh[i] = sh; tv_e[i] = e;
  endtask

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 32; i++) begin
      f_xor[i] = 32'd0;
      f_flag[i] = 2'b00;
    end
  endtask

  // Reference: replay the vector list through the faulty ALU and tally.
  task automatic model(output logic e_pass, output int e_fc, output int e_ffi,
                       output logic [31:0] e_cap, output logic [1:0] e_capf);
    logic [31:0] r;
    logic z, n;
    e_fc = 0; e_ffi = 31; e_cap = 0; e_capf = 0;
    for (int i = 0; i < 17; i++) begin
      r = alu_fn(tv_op[i], tv_a[i], tv_b[i], tv_sh[i]) ^ f_xor[tv_op[i]];
      z = (r == 0) ^ f_flag[tv_op[i]][1];
      n = r[31] ^ f_flag[tv_op[i]][0];
      if (r != tv_e[i] || z != (tv_e[i] == 0) || n != tv_e[i][31]) begin
        if (e_fc == 0) begin e_ffi = i; e_cap = r; e_capf = {z, n}; end
        e_fc++;
      end
    end
    e_pass = (e_fc == 0);
  endtask

  // Start both instances; cycle k is sampled on the negedge after the k-th
  // rising edge following the start-accept edge. Optionally re-pulse start mid-run.
  task automatic do_run(input bit poke, output int lat_a, output int lat_b, output int np_a);
    lat_a = -1; lat_b = -1; np_a = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      start = (poke && k == 5);
      if (done_a) begin np_a++; if (lat_a < 0) lat_a = k; end
      if (done_b && lat_b < 0) lat_b = k;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input bit poke, input logic e_pass, input int e_fc, input int e_ffi,
                           input logic [31:0] e_cap, input logic [1:0] e_capf);
    int la, lb, np;
    do_run(poke, la, lb, np);
    chk("lat_a", la, 51);
    chk("done_pulses_a", np, 1);
    chk("pass_a", pass_a, e_pass);
    chk("fail_count_a", fc_a, e_fc);
    chk("first_fail_a", ffi_a, e_ffi);
    chk("busy_a_after", busy_a, 0);
    chk("op_a_after", op_a, `ALU_OP_NONE);
    chk("lat_b", lb, (e_fc > 0) ? 3 * (e_ffi + 1) : 51);
    chk("pass_b", pass_b, e_pass);
    chk("fail_count_b", fc_b, (e_fc > 0) ? 1 : 0);
    chk("first_fail_b", ffi_b, e_ffi);
`ifdef ALU_BIST_CAPTURE_EN
    chk("cap_out_a", cap_a, e_cap);
    chk("cap_flags_a", capf_a, e_capf);
    chk("cap_out_b", cap_b, e_cap);
`else
    chk("cap_out_a", cap_a, 0);
    chk("cap_flags_a", capf_a, 0);
`endif
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] xmask;
    logic [1:0]  fflag;
    logic        e_pass;
    int          e_fc;
    int          e_ffi;
    logic [31:0] e_cap;
    logic [1:0]  e_capf;
  } tcase_t;

  tcase_t tc [0:4];

  initial begin
    logic        m_pass;
    int          m_fc, m_ffi, la, lb, np, nd;
    logic [31:0] m_cap;
    logic [1:0]  m_capf;
    logic [4:0]  rop;

    set_tv(0,  `ALU_OP_ADD,  32'h1,        32'h2,        5'd0, 32'h3);
    set_tv(1,  `ALU_OP_ADD,  32'h7fffffff, 32'h1,        5'd0, 32'h80000000);
    set_tv(2,  `ALU_OP_SUB,  32'h2,        32'h2,        5'd0, 32'h0);
    set_tv(3,  `ALU_OP_MUL,  32'h2,        32'h3,        5'd0, 32'h6);
    set_tv(4,  `ALU_OP_DIV,  32'h7,        32'h3,        5'd0, 32'h2);
    set_tv(5,  `ALU_OP_MOD,  32'h7,        32'h3,        5'd0, 32'h1);
    set_tv(6,  `ALU_OP_SLT,  32'h1,        32'h2,        5'd0, 32'h1);
    set_tv(7,  `ALU_OP_AND,  32'h00ff00ff, 32'h0000ffff, 5'd0, 32'h000000ff);
    set_tv(8,  `ALU_OP_OR,   32'h00ff00ff, 32'h0000ffff, 5'd0, 32'h00ffffff);
    set_tv(9,  `ALU_OP_XOR,  32'h00ff00ff, 32'h0000ffff, 5'd0, 32'h00ffff00);
    set_tv(10, `ALU_OP_NOR,  32'h00ff00ff, 32'h0000ffff, 5'd0, 32'hff000000);
    set_tv(11, `ALU_OP_SLL,  32'h0,        32'h000ff000, 5'd4, 32'h00ff0000);
    set_tv(12, `ALU_OP_SLLV, 32'h8,        32'h000ff000, 5'd0, 32'h0ff00000);
    set_tv(13, `ALU_OP_SRL,  32'h0,        32'h000ff000, 5'd4, 32'h0000ff00);
    set_tv(14, `ALU_OP_SRLV, 32'h8,        32'h000ff000, 5'd0, 32'h00000ff0);
    set_tv(15, `ALU_OP_SRA,  32'h0,        32'hfffffff8, 5'd1, 32'hfffffffc);
    set_tv(16, `ALU_OP_SRAV, 32'h2,        32'hfffffff8, 5'd0, 32'hfffffffe);

    // {fault op, xor mask, flag xor, pass, fail_count, first_fail, cap_out, cap_flags}
    tc[0] = '{`ALU_OP_ADD,  32'h0,        2'b00, 1'b1, 0, 31, 32'h0,        2'b00};
    tc[1] = '{`ALU_OP_ADD,  32'h1,        2'b00, 1'b0, 2, 0,  32'h00000002, 2'b00};
    tc[2] = '{`ALU_OP_SUB,  32'h0,        2'b10, 1'b0, 1, 2,  32'h00000000, 2'b00};
    tc[3] = '{`ALU_OP_NOR,  32'h80000000, 2'b00, 1'b0, 1, 10, 32'h7f000000, 2'b00};
    tc[4] = '{`ALU_OP_SRAV, 32'h0,        2'b01, 1'b0, 1, 16, 32'hfffffffe, 2'b00};

    clear_faults();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ffi", ffi_a, 5'h1F);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_pass", pass_a, 0);
    chk("reset_fc", fc_a, 0);
    chk("reset_ffi", ffi_a, 5'h1F);
    chk("reset_op", op_a, `ALU_OP_NONE);
    chk("reset_in1", in1_a, 0);
    chk("reset_in2", in2_a, 0);
    chk("reset_sh", sh_a, 0);
    chk("reset_cap", cap_a, 0);
    chk("reset_capf", capf_a, 0);

    // Directed table; the first case also re-pulses start while busy.
    for (int t = 0; t < 5; t++) begin
      clear_faults();
      f_xor[tc[t].op] = tc[t].xmask;
      f_flag[tc[t].op] = tc[t].fflag;
      check_run(t == 0, tc[t].e_pass, tc[t].e_fc, tc[t].e_ffi, tc[t].e_cap, tc[t].e_capf);
    end

    // Abort 10 cycles into a run with the ADD fault present.
    clear_faults();
    f_xor[`ALU_OP_ADD] = 32'h1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_op", op_a, `ALU_OP_NONE);
    chk("abort_in1", in1_a, 0);
    chk("abort_pass", pass_a, 0);
    chk("abort_fc_kept", fc_a, 2);
    chk("abort_ffi_kept", ffi_a, 0);
    nd = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("abort_no_done", nd, 0);

    // Reset mid-run, then a clean run.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_fc", fc_a, 0);
    chk("midrst_ffi", ffi_a, 5'h1F);
    chk("midrst_op", op_a, `ALU_OP_NONE);
    chk("midrst_in2", in2_a, 0);
    chk("midrst_busy_b", busy_b, 0);
    @(negedge clk); rst_n = 1'b1;
    clear_faults();
    check_run(1'b0, 1'b1, 0, 31, 32'h0, 2'b00);

    // Randomised fault sets against the reference model.
    for (int it = 0; it < 20; it++) begin
      clear_faults();
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        rop = 5'($urandom_range(1, 16));
        f_xor[rop] = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
        f_flag[rop] = 2'($urandom_range(0, 3));
      end
      model(m_pass, m_fc, m_ffi, m_cap, m_capf);
      check_run(1'($urandom_range(0, 1)), m_pass, m_fc, m_ffi, m_cap, m_capf);
    end

    la = 0; lb = 0; np = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
